// File: rtl/fic_ahb_arbiter_if.sv
// AHB-Lite bus bundle between the FIC_0 arbiter and the HPMS master port.
// The arbiter uses the master view; the system side uses the slave view.
interface fic_ahb_arbiter_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        output HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        input  HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/fic_ahb_arbiter.sv
// Round-robin arbiter sharing the FIC_0 AHB-Lite master among fabric clients.
// One single-beat transfer per grant, gated by bus_en, with a wait timeout.
module fic_ahb_arbiter #(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned TIMEOUT   = 1023,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic               mclk,
    input  logic               reset,
    input  logic               bus_en,
    input  logic [NREQ-1:0]    req,
    input  logic [32*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]    req_write,
    input  logic [32*NREQ-1:0] req_wdata,
    input  logic [3*NREQ-1:0]  req_size,
    output logic [NREQ-1:0]    ack,
    output logic [31:0]        rdata,
    output logic               err,
    output logic               timeout,
    output logic               busy,
    output logic [2:0]         grant_id,
    fic_ahb_arbiter_if.master  ahb
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [2:0]  LAST_ID = 3'(NREQ - 1);

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  grant_q, grant_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tout_q, tout_d;

    // Requester fields unpacked into 8-entry tables indexed by a 3-bit id
    logic [7:0]  req_pad;
    logic [7:0]  wr_pad;
    logic [31:0] addr_a  [8];
    logic [31:0] wdata_a [8];
    logic [2:0]  size_a  [8];

    for (genvar i = 0; i < 8; i++) begin : g_unp
        if (i < NREQ) begin : g_on
            assign req_pad[i] = req[i];
            assign wr_pad[i]  = req_write[i];
            assign addr_a[i]  = req_addr[32*i +: 32];
            assign wdata_a[i] = req_wdata[32*i +: 32];
            assign size_a[i]  = req_size[3*i +: 3];
        end else begin : g_off
            assign req_pad[i] = 1'b0;
            assign wr_pad[i]  = 1'b0;
            assign addr_a[i]  = '0;
            assign wdata_a[i] = '0;
            assign size_a[i]  = '0;
        end
    end

    logic       found;
    logic [2:0] sel;
    logic [3:0] idx;
    logic       illegal;

    // First pending requester at or after the round-robin pointer
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + 4'(k);
            if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
            if (!found && req_pad[idx[2:0]]) begin
                found = 1'b1;
                sel   = idx[2:0];
            end
        end
    end

    // Size/alignment legality of the selected request
    always_comb begin
        illegal = (size_a[sel] > 3'd2)
               || (size_a[sel] == 3'd1 && addr_a[sel][0])
               || (size_a[sel] == 3'd2 && addr_a[sel][1:0] != 2'b00);
    end

    // State and transfer registers
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            size_q  <= '0;
            wcnt_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            wcnt_q  <= wcnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
        end
    end

    // Next-state: grant, address phase, data phase with timeout, completion
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        wcnt_d  = wcnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tout_d  = tout_q;
        unique case (state_q)
            IDLE: begin
                if (bus_en && found) begin
                    grant_d = sel;
                    addr_d  = addr_a[sel];
                    write_d = wr_pad[sel];
                    wdata_d = wdata_a[sel];
                    size_d  = size_a[sel];
                    if (illegal) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (ahb.HREADY) begin
                    wcnt_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ahb.HREADY) begin
                    rdata_d = write_q ? 32'd0 : ahb.HRDATA;
                    err_d   = (ahb.HRESP == 2'b01);
                    state_d = DONE;
                end else if (wcnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            DONE: begin
                ptr_d   = (grant_q == LAST_ID) ? 3'd0 : grant_q + 3'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion pulse to the granted requester
    always_comb begin
        ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = (state_q == DONE) && (grant_q == 3'(i));
        end
    end

    assign rdata         = rdata_q;
    assign err           = err_q;
    assign timeout       = tout_q;
    assign busy          = (state_q != IDLE);
    assign grant_id      = grant_q;
    assign ahb.HADDR     = addr_q;
    assign ahb.HTRANS    = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign ahb.HWRITE    = write_q;
    assign ahb.HSIZE     = size_q;
    assign ahb.HBURST    = 3'b000;
    assign ahb.HPROT     = HPROT_VAL;
    assign ahb.HMASTLOCK = 1'b0;
    assign ahb.HWDATA    = wdata_q;
endmodule
